pixel_stream_source: RTL and testbench

Upstream driver for the Bradford image processor's pixel input port. It walks a frame stored in a 1-cycle-latency read memory in raster order. Each pixel is presented on a valid/ready stream that connects directly to the processor's input_rgb/input_valid/input_ready. It also generates start/end-of-line/frame markers and a frame_done strobe for the frame controller.

---
 rtl/pixel_stream_source.sv | 197 +++++++++++++++++++
 tb/tb_pixel_stream_source.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_stream_source.sv
// pixel_stream_source
// Reads one frame from a 1-cycle-latency memory in raster order and presents
// each pixel on a valid/ready stream with start/end-of-line/frame markers.
// A frame_done pulse follows the last accepted pixel.
//
// Optional build macro: PIXEL_SRC_TEST_PATTERN_EN
//   When defined, the memory is never read. Each pixel is loaded from an
//   eight-bar colour pattern indexed by horizontal position. When undefined,
//   only the memory path exists.

module pixel_stream_source #(
    parameter int IMG_WIDTH  = 320,
    parameter int IMG_HEIGHT = 240,
    parameter int ADDR_W     = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              matrix_valid,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [23:0]       mem_rd_data,
    output logic [23:0]       pix_rgb,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              pix_sof,
    output logic              pix_eol,
    output logic              pix_eof,
    output logic              busy,
    output logic              frame_done
);

    localparam int XW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_HOLD,
        S_DONE
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [XW-1:0]       x_cnt;
    logic [YW-1:0]       y_cnt;
    logic [ADDR_W-1:0]   addr_cnt;
    logic [23:0]         pix_reg;
    logic [23:0]         load_value;
    logic                xfer;
    logic                at_eol;
    logic                at_last_line;
    logic                last_pixel;

    // The downstream processor captures on valid alone, so valid already
    // includes its ready and the matrix qualifier: valid means transfer.
    assign xfer         = (state_q == S_HOLD) && pix_ready && matrix_valid;
    assign at_eol       = (x_cnt == X_LAST);
    assign at_last_line = (y_cnt == Y_LAST);
    assign last_pixel   = at_eol && at_last_line;

`ifdef PIXEL_SRC_TEST_PATTERN_EN
    // Colour bar for a given column: eight equal-width bars across the line.
    function automatic logic [23:0] bar_colour(input logic [XW-1:0] x);
        int bar;
        bar = (int'(x) * 8) / IMG_WIDTH;
        case (bar)
            0:       bar_colour = 24'hFFFFFF;
            1:       bar_colour = 24'hFFFF00;
            2:       bar_colour = 24'h00FFFF;
            3:       bar_colour = 24'h00FF00;
            4:       bar_colour = 24'hFF00FF;
            5:       bar_colour = 24'hFF0000;
            6:       bar_colour = 24'h0000FF;
            default: bar_colour = 24'h000000;
        endcase
    endfunction

    // Memory data is deliberately ignored in pattern mode.
    logic unused_mem_rd_data;
    assign unused_mem_rd_data = ^mem_rd_data;
    assign load_value         = bar_colour(x_cnt);
`else
    assign load_value         = mem_rd_data;
`endif

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and all state-derived outputs.
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d     = state_q;
        mem_rd_en   = 1'b0;
        mem_rd_addr = '0;
        pix_valid   = 1'b0;
        pix_sof     = 1'b0;
        pix_eol     = 1'b0;
        pix_eof     = 1'b0;
        busy        = 1'b1;
        frame_done  = 1'b0;

        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
`ifndef PIXEL_SRC_TEST_PATTERN_EN
                mem_rd_en = 1'b1;
`endif
                mem_rd_addr = addr_cnt;
                state_d     = S_WAIT;
            end
            S_WAIT: begin
                state_d = S_HOLD;
            end
            S_HOLD: begin
                pix_valid = xfer;
                pix_sof   = xfer && (x_cnt == '0) && (y_cnt == '0);
                pix_eol   = xfer && at_eol;
                pix_eof   = xfer && last_pixel;
                if (xfer) begin
                    state_d = last_pixel ? S_DONE : S_FETCH;
                end
            end
            S_DONE: begin
                frame_done = 1'b1;
                state_d    = S_IDLE;
            end
            default: begin
                busy    = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Raster position and linear address; cleared on start, advanced on
    // each accepted pixel except the last so they never wrap mid-frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_cnt    <= '0;
            y_cnt    <= '0;
            addr_cnt <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        x_cnt    <= '0;
                        y_cnt    <= '0;
                        addr_cnt <= '0;
                    end
                end
                S_HOLD: begin
                    if (xfer && !last_pixel) begin
                        addr_cnt <= addr_cnt + 1'b1;
                        if (at_eol) begin
                            x_cnt <= '0;
                            y_cnt <= y_cnt + 1'b1;
                        end else begin
                            x_cnt <= x_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Pixel holding register: loaded once per pixel in WAIT, then held
    // stable through HOLD for however long the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_reg <= '0;
        end else if (state_q == S_WAIT) begin
            pix_reg <= load_value;
        end
    end

    assign pix_rgb = pix_reg;

endmodule

// File: tb/tb_pixel_stream_source.sv
// Self-checking bench for pixel_stream_source.
// Default build: 4x2 frame read from a memory model.
// With PIXEL_SRC_TEST_PATTERN_EN: 8x1 frame of colour bars, memory unused.

module tb_pixel_stream_source;

`ifdef PIXEL_SRC_TEST_PATTERN_EN
    localparam int W = 8;
    localparam int H = 1;
`else
    localparam int W = 4;
    localparam int H = 2;
`endif
    localparam int N  = W * H;
    localparam int AW = 17;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          matrix_valid;
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [23:0]   mem_rd_data = '0;
    logic [23:0]   pix_rgb;
    logic          pix_valid;
    logic          pix_ready;
    logic          pix_sof;
    logic          pix_eol;
    logic          pix_eof;
    logic          busy;
    logic          frame_done;

    logic [23:0]   mem [N];
    int            checks   = 0;
    int            failures = 0;

    pixel_stream_source #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .ADDR_W     (AW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .matrix_valid (matrix_valid),
        .mem_rd_en    (mem_rd_en),
        .mem_rd_addr  (mem_rd_addr),
        .mem_rd_data  (mem_rd_data),
        .pix_rgb      (pix_rgb),
        .pix_valid    (pix_valid),
        .pix_ready    (pix_ready),
        .pix_sof      (pix_sof),
        .pix_eol      (pix_eol),
        .pix_eof      (pix_eof),
        .busy         (busy),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    // 1-cycle-latency memory; returns noise on cycles without a read.
    always @(posedge clk) begin
        if (mem_rd_en)
            mem_rd_data <= (int'(mem_rd_addr) < N) ? mem[int'(mem_rd_addr)] : 24'hDEAD00;
        else
            mem_rd_data <= 24'($urandom);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference pixel value for raster index k.
    function automatic logic [23:0] exp_rgb(input int k);
`ifdef PIXEL_SRC_TEST_PATTERN_EN
        int bar;
        bar = ((k % W) * 8) / W;
        case (bar)
            0:       return 24'hFFFFFF;
            1:       return 24'hFFFF00;
            2:       return 24'h00FFFF;
            3:       return 24'h00FF00;
            4:       return 24'hFF00FF;
            5:       return 24'hFF0000;
            6:       return 24'h0000FF;
            default: return 24'h000000;
        endcase
`else
        return mem[k];
`endif
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_rgb"},   pix_rgb,     0);
        check({tag, "_valid"}, pix_valid,   0);
        check({tag, "_marks"}, {pix_sof, pix_eol, pix_eof}, 0);
        check({tag, "_busy"},  busy,        0);
        check({tag, "_done"},  frame_done,  0);
        check({tag, "_rden"},  mem_rd_en,   0);
        check({tag, "_addr"},  mem_rd_addr, 0);
    endtask

    task automatic fill_mem(input bit ramp);
        for (int i = 0; i < N; i++)
            mem[i] = ramp ? {i[7:0], i[7:0], i[7:0]} : 24'($urandom);
    endtask

    // Stream one frame. Expected timing: after start (cycle 0) or a transfer
    // (cycle c), FETCH is c+1, WAIT c+2, and the pixel is offered from c+3.
    // mode 0: always ready; 1: ready low for 10 HOLD cycles of pixel 0;
    // 2: matrix_valid low mid-frame; 3: random ready/matrix/spurious starts.
    // abort_k > 0 returns right after that many pixels were accepted.
    task automatic stream_frame(input int mode, input int abort_k);
        int k    = 0;
        int last = 0;
        @(posedge clk);
        #1;
        start        = 1'b1;
        pix_ready    = 1'b1;
        matrix_valid = 1'b1;
        @(negedge clk);
        check("idle_busy",  busy,      0);
        check("idle_valid", pix_valid, 0);
        for (int cyc = 1; cyc < 3000; cyc++) begin
            bit r;
            bit m;
            @(posedge clk);
            #1;
            case (mode)
                1:       begin r = !(cyc >= 3 && cyc < 13); m = 1'b1; end
                2:       begin r = 1'b1; m = !(cyc >= 9 && cyc < 19); end
                3:       begin r = ($urandom_range(0, 99) < 60); m = ($urandom_range(0, 99) < 80); end
                default: begin r = 1'b1; m = 1'b1; end
            endcase
            pix_ready    = r;
            matrix_valid = m;
            start        = (mode == 3 && !(k == N && cyc == last + 2)) ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
            if (k < N) begin
                check("busy",       busy,       1);
                check("done_early", frame_done, 0);
                if (cyc < last + 3) begin
                    check("gap_valid", pix_valid, 0);
`ifdef PIXEL_SRC_TEST_PATTERN_EN
                    check("rd_en", mem_rd_en, 0);
`else
                    check("rd_en", mem_rd_en, (cyc == last + 1));
                    if (cyc == last + 1)
                        check("rd_addr", mem_rd_addr, k);
`endif
                end else begin
                    check("rd_en_hold", mem_rd_en, 0);
                    check("hold_rgb",   pix_rgb,   exp_rgb(k));
                    check("valid",      pix_valid, r & m);
                    if (pix_valid) begin
                        check("sof", pix_sof, (k == 0));
                        check("eol", pix_eol, (k % W == W - 1));
                        check("eof", pix_eof, (k == N - 1));
                        k++;
                        last = cyc;
                        if (k == abort_k)
                            return;
                    end else begin
                        check("marks_idle", {pix_sof, pix_eol, pix_eof}, 0);
                    end
                end
            end else begin
                check("post_valid", pix_valid, 0);
                check("post_rden",  mem_rd_en, 0);
                if (cyc == last + 1) begin
                    check("frame_done", frame_done, 1);
                    check("done_busy",  busy,       1);
                end else begin
                    check("done_once",  frame_done, 0);
                    check("end_busy",   busy,       0);
                    return;
                end
            end
        end
        check("frame_timeout", k, N);
    endtask

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        pix_ready    = 1'b0;
        matrix_valid = 1'b0;
        fill_mem(1'b1);
        #12;
        check_all_zero("reset");
        @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // Ramp memory, full-rate consumer.
        stream_frame(0, 0);
        // Consumer ready stall in HOLD.
        fill_mem(1'b0);
        stream_frame(1, 0);
        // Matrix-valid stall mid-frame.
        fill_mem(1'b0);
        stream_frame(2, 0);
        // Random handshake with spurious start pulses while busy.
        fill_mem(1'b0);
        stream_frame(3, 0);

        // Reset after pixel 2 (third pixel) is accepted.
        fill_mem(1'b0);
        stream_frame(0, 3);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("abort");
        @(posedge clk);
        #2;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("abort_done", frame_done, 0);
            check("abort_busy", busy,       0);
        end
        // Frame after reset restarts from address 0 with sof.
        stream_frame(0, 0);

        for (int f = 0; f < 3; f++) begin
            fill_mem(1'b0);
            stream_frame(3, 0);
        end

        // Idle with start low: nothing happens.
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle_quiet", {busy, pix_valid, frame_done, mem_rd_en}, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
